// File: rtl/pipeline_stage_skid.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer, sync flush, bubble ctrl override.
// Latency 1 cycle; SKID=1 gives a flop-driven in_ready (stalls when skid is full), SKID=0 gives a combinational in_ready.
module pipeline_stage_skid #(
  parameter int                DATA_W      = 160,
  parameter int                CTRL_W      = 9,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter bit                SKID        = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              accept;
  logic              pop;
  logic [CTRL_W-1:0] in_ctrl_eff;
  logic              head_vld;
  logic [DATA_W-1:0] head_dat;
  logic [CTRL_W-1:0] head_ctl;

  assign accept      = in_valid & in_ready;
  assign pop         = head_vld & out_ready;
  assign in_ctrl_eff = bubble ? CTRL_BUBBLE : in_ctrl;

  assign out_valid = head_vld;
  assign out_data  = head_dat;
  assign out_ctrl  = head_ctl;

  generate
    if (SKID) begin : g_skid
      logic              skid_vld;
      logic [DATA_W-1:0] skid_dat;
      logic [CTRL_W-1:0] skid_ctl;

      // skid_vld is a flop, so in_ready never depends on out_ready
      assign in_ready  = ~skid_vld;
      assign occupancy = {skid_vld, head_vld ^ skid_vld};

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          head_vld <= 1'b0;
          head_dat <= '0;
          head_ctl <= CTRL_BUBBLE;
          skid_vld <= 1'b0;
          skid_dat <= '0;
          skid_ctl <= CTRL_BUBBLE;
        end else if (flush) begin
          head_vld <= 1'b0;
          head_ctl <= CTRL_BUBBLE;
          skid_vld <= 1'b0;
          skid_ctl <= CTRL_BUBBLE;
        end else if (skid_vld) begin
          if (pop) begin
            head_dat <= skid_dat;
            head_ctl <= skid_ctl;
            skid_vld <= 1'b0;
            skid_ctl <= CTRL_BUBBLE;
          end
        end else if (head_vld) begin
          if (accept && pop) begin
            head_dat <= in_data;
            head_ctl <= in_ctrl_eff;
          end else if (accept) begin
            skid_vld <= 1'b1;
            skid_dat <= in_data;
            skid_ctl <= in_ctrl_eff;
          end else if (pop) begin
            head_vld <= 1'b0;
            head_ctl <= CTRL_BUBBLE;
          end
        end else if (accept) begin
          head_vld <= 1'b1;
          head_dat <= in_data;
          head_ctl <= in_ctrl_eff;
        end
      end
    end else begin : g_noskid
      assign in_ready  = ~head_vld | out_ready;
      assign occupancy = {1'b0, head_vld};

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          head_vld <= 1'b0;
          head_dat <= '0;
          head_ctl <= CTRL_BUBBLE;
        end else if (flush) begin
          head_vld <= 1'b0;
          head_ctl <= CTRL_BUBBLE;
        end else if (accept) begin
          head_vld <= 1'b1;
          head_dat <= in_data;
          head_ctl <= in_ctrl_eff;
        end else if (pop) begin
          head_vld <= 1'b0;
          head_ctl <= CTRL_BUBBLE;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Scoreboard bench for pipeline_stage_skid: SKID=1 instance (sel=0) and SKID=0 instance (sel=1).
module tb_pipeline_stage_skid;
  localparam int DW = 160;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sel = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          bubble = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;

  logic          rdy_a, vld_a, rdy_b, vld_b;
  logic [DW-1:0] dat_a, dat_b;
  logic [CW-1:0] ctl_a, ctl_b;
  logic [1:0]    occ_a, occ_b;

  logic          in_ready_m, out_valid_m;
  logic [DW-1:0] out_data_m;
  logic [CW-1:0] out_ctrl_m;
  logic [1:0]    occ_m;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW+CW-1:0] q[$];

  always #5 clk = ~clk;

  pipeline_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE('0), .SKID(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(rdy_a),
    .in_data(in_data), .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush & ~sel),
    .out_valid(vld_a), .out_ready(out_ready), .out_data(dat_a), .out_ctrl(ctl_a),
    .occupancy(occ_a)
  );

  pipeline_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE('0), .SKID(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(rdy_b),
    .in_data(in_data), .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush & sel),
    .out_valid(vld_b), .out_ready(out_ready), .out_data(dat_b), .out_ctrl(ctl_b),
    .occupancy(occ_b)
  );

  assign in_ready_m  = sel ? rdy_b : rdy_a;
  assign out_valid_m = sel ? vld_b : vld_a;
  assign out_data_m  = sel ? dat_b : dat_a;
  assign out_ctrl_m  = sel ? ctl_b : ctl_a;
  assign occ_m       = sel ? occ_b : occ_a;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop seen on the selected stage is checked against the queue head.
  always @(negedge clk) begin
    logic [DW+CW-1:0] e;
    if (rst && out_valid_m && out_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: got data %0h ctrl %0h, expected no entry", out_data_m, out_ctrl_m);
      end else begin
        e = q.pop_front();
        if ({out_data_m, out_ctrl_m} !== e) begin
          n_err++;
          $display("FAIL sb_entry: got data %0h ctrl %0h, expected data %0h ctrl %0h",
                   out_data_m, out_ctrl_m, e[DW+CW-1:CW], e[CW-1:0]);
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    bubble   = b;
    @(negedge clk);
    while (!in_ready_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_m) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready 0 for data %0h, expected 1", d);
    end else begin
      q.push_back({d, b ? 9'h000 : c});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bubble   = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    // T1 reset with in_valid high
    in_valid = 1'b1;
    in_data  = 160'h55;
    repeat (2) @(negedge clk);
    chk("t1_out_valid", DW'(vld_a), 0);
    chk("t1_out_ctrl", DW'(ctl_a), 0);
    chk("t1_occ_a", DW'(occ_a), 0);
    chk("t1_occ_b", DW'(occ_b), 0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t1_in_ready", DW'(rdy_a), 1);
    tick(1);

    // T2 streaming, one cycle latency
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send(DW'(i), CW'(i + 8), 1'b0);
      chk("t2_lat_data", dat_a, DW'(i));
      chk("t2_in_ready", DW'(rdy_a), 1);
    end
    tick(2);
    chk("t2_drained", DW'(q.size()), 0);

    // T3 backpressure fills skid
    out_ready = 1'b0;
    send(160'hA, 9'h012, 1'b0);
    send(160'hB, 9'h034, 1'b0);
    chk("t3_occ_full", DW'(occ_a), 2);
    chk("t3_in_ready", DW'(rdy_a), 0);
    chk("t3_head", dat_a, 160'hA);
    out_ready = 1'b1;
    tick(3);
    chk("t3_occ_empty", DW'(occ_a), 0);
    chk("t3_drained", DW'(q.size()), 0);

    // T4 bubble overrides ctrl, data passes
    out_ready = 1'b0;
    send(160'h1234_5678_9ABC, 9'h1FF, 1'b1);
    chk("t4_ctrl", DW'(ctl_a), 0);
    chk("t4_data", dat_a, 160'h1234_5678_9ABC);
    out_ready = 1'b1;
    send(160'hDEAD_BEEF, 9'h1FF, 1'b0);
    chk("t4_nobubble_ctrl", DW'(ctl_a), 9'h1FF);
    tick(2);
    chk("t4_idle_valid", DW'(vld_a), 0);
    chk("t4_idle_ctrl", DW'(ctl_a), 0);

    // T5 flush while FULL with input offered
    out_ready = 1'b0;
    send(160'hC, 9'h0C1, 1'b0);
    send(160'hD, 9'h0D1, 1'b0);
    in_valid = 1'b1;
    in_data  = 160'hE;
    in_ctrl  = 9'h0E1;
    flush    = 1'b1;
    tick(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("t5_out_valid", DW'(vld_a), 0);
    chk("t5_occ", DW'(occ_a), 0);
    chk("t5_in_ready", DW'(rdy_a), 1);
    chk("t5_ctrl", DW'(ctl_a), 0);
    out_ready = 1'b1;
    tick(3);
    chk("t5_discard", DW'(vld_a), 0);

    // Flush coinciding with a pop: the pop still reaches downstream
    out_ready = 1'b0;
    send(160'hF, 9'h0F1, 1'b0);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("t5_pop_seen", DW'(q.size()), 0);
    chk("t5_pop_valid", DW'(vld_a), 0);

    // Async reset while FULL
    out_ready = 1'b0;
    send(160'h71, 9'h071, 1'b0);
    send(160'h72, 9'h072, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t7_valid", DW'(vld_a), 0);
    chk("t7_occ", DW'(occ_a), 0);
    chk("t7_ctrl", DW'(ctl_a), 0);
    q.delete();
    #2 rst = 1'b1;
    tick(1);
    chk("t7_in_ready", DW'(rdy_a), 1);

    // T6 SKID=0 instance
    sel = 1'b1;
    tick(1);
    send(160'h61, 9'h011, 1'b0);
    chk("t6_occ", DW'(occ_b), 1);
    chk("t6_in_ready_stall", DW'(rdy_b), 0);
    out_ready = 1'b1;
    #1;
    chk("t6_in_ready_comb", DW'(rdy_b), 1);
    send(160'h62, 9'h022, 1'b0);
    chk("t6_replace_occ", DW'(occ_b), 1);
    chk("t6_replace_data", dat_b, 160'h62);
    tick(2);
    chk("t6_drained", DW'(vld_b), 0);
    chk("t6_sb_empty", DW'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
